// File: rtl/hdmi_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_video_timing_ctrl
// Description : Fixed-mode DVI/HDMI raster timing. Issues pixel-coordinate
//               requests LOOKAHEAD cycles ahead of the encoders, then delays
//               VDE, sync and control codes so they meet the returned pixel.
//               Optional macro HDMI_PREAMBLE_EN adds the video preamble
//               (CTL0 on the green channel) and the leading guard band.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_video_timing_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOOKAHEAD = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  output logic [11:0] req_x,
  output logic [11:0] req_y,
  output logic        frame_start,
  output logic        line_start,
  output logic        vde,
  output logic [1:0]  cd_blue,
  output logic [1:0]  cd_green,
  output logic [1:0]  cd_red,
  output logic        guard_band
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);

  // Stage word layout: {guard, cd_red[1:0], cd_green[1:0], cd_blue[1:0], vde}
  localparam logic [7:0] INACTIVE = {1'b0, 2'b00, 2'b00, ~VSYNC_POL, ~HSYNC_POL, 1'b0};

  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        active;
  logic        hsync_on;
  logic        vsync_on;
  logic [3:0]  ctl;
  logic        guard;
  logic [7:0]  stage_in;
  // Index 0 is the request stage; index LOOKAHEAD feeds the encoders.
  logic [7:0]  pipe [LOOKAHEAD+1];

`ifdef HDMI_PREAMBLE_EN
  localparam logic [11:0] PRE_START = 12'(H_TOTAL - 10);
  localparam logic [11:0] PRE_END   = 12'(H_TOTAL - 3);
  localparam logic [11:0] GB_START  = 12'(H_TOTAL - 2);
  logic [11:0] next_line;
`endif

  // Raster counters: hcount wraps every line, vcount every frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST) ? 12'd0 : vcount + 12'd1;
    end else begin
      hcount <= hcount + 12'd1;
    end
  end

  // Per-position video flags, evaluated on the current count.
  always_comb begin
    active   = (hcount < H_ACT) && (vcount < V_ACT);
    hsync_on = (hcount >= HS_START) && (hcount < HS_END);
    vsync_on = (vcount >= VS_START) && (vcount < VS_END);
    ctl      = 4'b0000;
    guard    = 1'b0;
`ifdef HDMI_PREAMBLE_EN
    // Preamble/guard band lead into a line that carries video.
    next_line = (vcount == V_LAST) ? 12'd0 : vcount + 12'd1;
    if (next_line < V_ACT) begin
      if ((hcount >= PRE_START) && (hcount <= PRE_END)) ctl = 4'b0001;
      if (hcount >= GB_START) guard = 1'b1;
    end
`endif
    stage_in = {guard, ctl[3:2], ctl[1:0],
                vsync_on ? VSYNC_POL : ~VSYNC_POL,
                hsync_on ? HSYNC_POL : ~HSYNC_POL,
                active};
  end

  // Request stage registers, captured together with pipeline stage 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      req_valid   <= active;
      req_x       <= hcount;
      req_y       <= vcount;
      frame_start <= (hcount == 12'd0) && (vcount == 12'd0);
      line_start  <= (hcount == 12'd0) && (vcount < V_ACT);
    end
  end

  // Alignment shift register; reset flushes every stage to blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= LOOKAHEAD; i++) pipe[i] <= INACTIVE;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i <= LOOKAHEAD; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign vde        = pipe[LOOKAHEAD][0];
  assign cd_blue    = pipe[LOOKAHEAD][2:1];
  assign cd_green   = pipe[LOOKAHEAD][4:3];
  assign cd_red     = pipe[LOOKAHEAD][6:5];
  assign guard_band = pipe[LOOKAHEAD][7];

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_video_timing_ctrl
// Description : Bench for hdmi_video_timing_ctrl. Horizontal timing uses the
//               default 800-cycle line; vertical timing is shortened to a
//               65-line frame (48 active) so a whole frame stays short.
//               Build with HDMI_PREAMBLE_EN to cover the preamble feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_video_timing_ctrl #(
  parameter int L = 2
);
  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
  localparam int VA = 48,  VFP = 10, VS = 2,  VBP = 5;
  localparam int HT = HA + HFP + HS + HBP;   // 800
  localparam int VT = VA + VFP + VS + VBP;   // 65
  localparam int FRAME = HT * VT;            // 52000
  localparam bit HP = 1'b0, VP = 1'b0;
`ifdef HDMI_PREAMBLE_EN
  localparam int PRE_ON = 1;
`else
  localparam int PRE_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, frame_start, line_start, vde, guard_band;
  logic [11:0] req_x, req_y;
  logic [1:0]  cd_blue, cd_green, cd_red;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;     // request cycles since reset release; -1 = reset state
  bit started  = 1'b0;

  always #5 clk = ~clk;

  hdmi_video_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .LOOKAHEAD(L)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .frame_start(frame_start), .line_start(line_start),
    .vde(vde), .cd_blue(cd_blue), .cd_green(cd_green), .cd_red(cd_red),
    .guard_band(guard_band)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Reference: outputs as a pure function of position since reset release.
  function automatic logic [34:0] model(input int tt);
    logic [34:0] r;
    int p, x, y, q, qx, qy, nxt;
    logic rv, fs, ls, v, hs, vs, gb;
    logic [1:0] gr;
    rv = 0; fs = 0; ls = 0; x = 0; y = 0;
    v = 0; hs = ~HP; vs = ~VP; gr = 2'b00; gb = 0;
    if (tt >= 0) begin
      p = tt % FRAME; x = p % HT; y = p / HT;
      rv = (x < HA) && (y < VA);
      fs = (p == 0);
      ls = (x == 0) && (y < VA);
      if (tt >= L) begin
        q = (tt - L) % FRAME; qx = q % HT; qy = q / HT;
        v  = (qx < HA) && (qy < VA);
        hs = ((qx >= HA + HFP) && (qx < HA + HFP + HS)) ? HP : ~HP;
        vs = ((qy >= VA + VFP) && (qy < VA + VFP + VS)) ? VP : ~VP;
        nxt = (qy + 1) % VT;
        if (PRE_ON == 1 && nxt < VA) begin
          if (qx >= HT - 10 && qx <= HT - 3) gr = 2'b01;
          if (qx >= HT - 2) gb = 1'b1;
        end
      end
    end
    r = {rv, 12'(x), 12'(y), fs, ls, v, vs, hs, gr, 2'b00, gb};
    return r;
  endfunction

  // Model time base follows the DUT's view of rst.
  always @(posedge clk) begin
    if (rst) begin
      t       <= -1;
      started <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  // Cycle-by-cycle comparison against the model (coordinates masked in reset).
  always @(negedge clk) begin
    logic [34:0] act, exp;
    if (started) begin
      exp = model(t);
      act = {req_valid, req_x, req_y, frame_start, line_start, vde,
             cd_blue, cd_green, cd_red, guard_band};
      if (t < 0) act[33:10] = '0;
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_model t=%0d: got %0h expected %0h", t, act, exp);
      end
    end
  end

  initial begin
    int ls_cnt = 0, rv_cnt = 0, fs_cnt = 0, pre_cnt = 0, gb_cnt = 0;
    int vde_l0 = 0, hs_l0 = 0, hs_first = -1, vs_first = -1, vs_last = -1;
    int waited;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // Cycle after reset release still shows the flushed state.
    chk("post_rst_vde", vde, 0);
    chk("post_rst_cd_blue", cd_blue, 2'b11);
    chk("post_rst_req_valid", req_valid, 0);

    for (int k = 0; k <= FRAME + L; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rel_req_x", req_x, 0);
        chk("rel_req_y", req_y, 0);
        chk("rel_frame_start", frame_start, 1);
      end
      if (k == L) chk("vde_rise", vde, 1);
      if (k < FRAME) begin
        ls_cnt += int'(line_start);
        rv_cnt += int'(req_valid);
        if (k > 0) fs_cnt += int'(frame_start);
      end
      if (k == FRAME) chk("next_frame_start", frame_start, 1);
      if (k >= L) begin
        if (k < HT + L) begin
          vde_l0 += int'(vde);
          if (!cd_blue[0]) begin
            hs_l0++;
            if (hs_first < 0) hs_first = k;
          end
        end
        if (!cd_blue[1]) begin
          if (vs_first < 0) vs_first = k;
          vs_last = k;
        end
        pre_cnt += int'(cd_green == 2'b01);
        gb_cnt  += int'(guard_band);
      end
    end
    chk("line0_vde_cycles", vde_l0, 640);
    chk("line0_hsync_cycles", hs_l0, 96);
    chk("line0_hsync_start", hs_first, 656 + L);
    chk("frame_line_starts", ls_cnt, 48);
    chk("frame_req_valid", rv_cnt, 30720);
    chk("frame_extra_frame_start", fs_cnt, 0);
    chk("vsync_first", vs_first, 58 * 800 + L);
    chk("vsync_last", vs_last, 60 * 800 - 1 + L);
    chk("preamble_cycles", pre_cnt, PRE_ON * 8 * 48);
    chk("guard_cycles", gb_cnt, PRE_ON * 2 * 48);

    // Mid-frame reset at request (300,10).
    waited = 0;
    while (!(req_x == 12'd300 && req_y == 12'd10) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    chk("reach_300_10", waited < 20000, 1);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_vde", vde, 0);
      chk("midrst_cd_blue", cd_blue, 2'b11);
      chk("midrst_req_valid", req_valid, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_frame_start", frame_start, 1);
    chk("midrst_req_xy", {req_x, req_y}, 24'd0);
    repeat (HT + L + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hdmi_video_timing_ctrl.md
Name: hdmi_video_timing_ctrl

Overview:
- Sequences the three TMDS channel encoders for a fixed-mode DVI/HDMI output.
- Runs horizontal and vertical raster counters and issues pixel-coordinate requests to the pixel generator (e.g. Mandelbrot LUT pipeline) LOOKAHEAD cycles early.
- Delays VDE and per-channel control data so they are cycle-aligned with the returned pixel at the encoder inputs.
- Sits between the pixel generator and the red/green/blue encoder instances, all in the pixel clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted hsync level
- VSYNC_POL, 0, asserted vsync level
- LOOKAHEAD, 2, pixel generator latency in cycles, legal 0..15

Ports:
- clk  input  1  pixel clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  output  1  coordinate request is for an active pixel
- req_x  output  12  requested pixel column
- req_y  output  12  requested pixel row
- frame_start  output  1  one-cycle pulse coincident with request (0,0)
- line_start  output  1  one-cycle pulse coincident with request (0,y), for y < V_ACTIVE
- vde  output  1  video data enable to all three encoders
- cd_blue  output  2  blue encoder CD = {vsync, hsync}
- cd_green  output  2  green encoder CD = {CTL1, CTL0}
- cd_red  output  2  red encoder CD = {CTL3, CTL2}
- guard_band  output  1  external mux selects the guard-band code instead of the encoder output

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Counters: hcount runs 0..H_TOTAL-1; at H_TOTAL-1 it wraps to 0 and vcount increments. vcount runs 0..V_TOTAL-1; at V_TOTAL-1, when hcount wraps, vcount wraps to 0.
- Active region: hcount < H_ACTIVE and vcount < V_ACTIVE.
- Request stage (registered from the counters, same cycle as the count):
  - req_x = hcount, req_y = vcount (zero-extended to 12 bits).
  - req_valid = active.
  - frame_start = (hcount==0 && vcount==0).
  - line_start = (hcount==0 && vcount<V_ACTIVE).
- hsync is asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. It changes only at hcount==0, i.e. line-aligned.
- Asserted level is the *_POL parameter; the idle level is its inverse.
- Alignment pipeline:
  - active, hsync, vsync and the CTL/guard flags computed at request cycle n drive vde/cd_*/guard_band at cycle n+LOOKAHEAD.
  - Implemented as a LOOKAHEAD-deep shift register; LOOKAHEAD=0 means direct registered outputs with no extra delay.
  - The pixel generator returns pixel data at n+LOOKAHEAD, so data and vde reach the encoder together.
- Reset, while rst=1 and on the first cycle after:
  - hcount=0, vcount=0.
  - All pipeline stages are flushed to the inactive state: vde=0, cd_blue={~VSYNC_POL,~HSYNC_POL}, cd_green=0, cd_red=0, guard_band=0.
  - req_valid=0, frame_start=0, line_start=0.
- After reset:
  - The first non-reset cycle presents request (0,0) with frame_start=1.
  - vde rises LOOKAHEAD cycles later.
  - Pipeline stages not yet filled since reset output the inactive state.
- Reset mid-frame: takes effect on the next clock edge regardless of position. Partial lines are discarded with no completion, and sync returns immediately to idle.
- A request is never issued for hcount >= H_ACTIVE or vcount >= V_ACTIVE; req_x/req_y still track the counters there.
- Without HDMI_PREAMBLE_EN, cd_green and cd_red are held at 2'b00.

Optional Feature:
- Macro: HDMI_PREAMBLE_EN.
- When defined, preamble and guard-band flags apply on every line L where the next line (vcount+1, mod V_TOTAL) is < V_ACTIVE:
  - Request stage hcount in H_TOTAL-10..H_TOTAL-3: cd_green = 2'b01 (CTL0=1, CTL1=0) and cd_red = 2'b00, i.e. the 8-cycle video preamble.
  - Request stage hcount H_TOTAL-2 and H_TOTAL-1: guard_band=1.
  - Both are delayed through the same pipeline as vde.
- When undefined, the preamble logic is absent, cd_green = cd_red = 0, and guard_band is tied to 0.

Test Plan:
- Reset release with defaults, LOOKAHEAD=2 -> cycle 0: req (0,0), frame_start=1, vde=0. Cycle 2: vde=1. vde stays 1 for exactly 640 cycles, then 0 for 160.
- Hsync timing -> cd_blue[0]=0 for exactly 96 cycles beginning 656+LOOKAHEAD cycles after each line_start, and =1 elsewhere.
- Full frame of 420000 cycles -> 480 line_start pulses and 307200 req_valid cycles. cd_blue[1]=0 spans lines 490-491 only. Next frame_start occurs at cycle 420000.
- LOOKAHEAD=0 and LOOKAHEAD=15 builds -> vde is the req_valid sequence delayed by exactly LOOKAHEAD cycles, checked over the full frame.
- Assert rst at request (300,100) for 3 cycles -> during and one cycle after reset: vde=0, cd_blue=2'b11, no req_valid. First post-reset cycle: req (0,0) with frame_start.
- HDMI_PREAMBLE_EN defined -> on line 524, cd_green=01 for 8 cycles, then guard_band=1 for 2 cycles, then vde rises at line 0 pixel 0. On line 479 (next line blanking), no preamble and no guard_band.
